// File: rtl/vessel_kinematics_if.sv
// -----------------------------------------------------------------------------
// vessel_kinematics_if
//
// Purpose: bundles the orbit-controller inputs and the vessel kinematic
//          outputs exchanged with vessel_kinematics.
//
// Signals:
//   state     [1:0]  orbit-controller state (00 bound, 01 leaving,
//                    10 unbound, 11 arriving)
//   theta     int    orbit angle, bits [7:0] used (256 steps per turn)
//   PlanX/Y/S int    centre and radius of the selected planet
//   VesselX/Y int    registered vessel centre
//   VesselS   int    vessel radius (constant)
//   vel_x/y   int    registered velocity in pixels per frame
//   edge_hit  1      one-cycle pulse after a playfield edge crossing
//
// Modports: master drives the controller inputs, slave is the kinematics block.
// -----------------------------------------------------------------------------
interface vessel_kinematics_if;
    logic [1:0] state;
    int         theta;
    int         PlanX;
    int         PlanY;
    int         PlanS;
    int         VesselX;
    int         VesselY;
    int         VesselS;
    int         vel_x;
    int         vel_y;
    logic       edge_hit;

    modport master (
        output state, theta, PlanX, PlanY, PlanS,
        input  VesselX, VesselY, VesselS, vel_x, vel_y, edge_hit
    );

    modport slave (
        input  state, theta, PlanX, PlanY, PlanS,
        output VesselX, VesselY, VesselS, vel_x, vel_y, edge_hit
    );
endinterface

// File: rtl/vessel_kinematics.sv
// -----------------------------------------------------------------------------
// vessel_kinematics
//
// Purpose: computes the vessel position and velocity each frame. While bound
//          the vessel sits on a circle around the selected planet; on leaving
//          it captures a tangent velocity; while unbound it drifts and is
//          handled at the playfield edges; while arriving it is parked.
//
// Ports:
//   frame_clk  in   one rising edge per frame
//   Reset      in   synchronous, active-high
//   kin        slave modport of vessel_kinematics_if (see that file)
//
// Build option:
//   SCREEN_WRAP_EN  defined   -> unbound vessel wraps around the playfield
//                   undefined -> unbound vessel clamps to the edge and the
//                                velocity of the clamped axis is zeroed
// -----------------------------------------------------------------------------
module vessel_kinematics #(
    parameter int VESSEL_SIZE = 4,
    parameter int ORBIT_GAP   = 8,
    parameter int SPEED       = 4,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int START_X     = 320,
    parameter int START_Y     = 240
) (
    input logic                 frame_clk,
    input logic                 Reset,
    vessel_kinematics_if.slave  kin
);

    typedef enum logic [1:0] {
        ST_BOUND    = 2'b00,
        ST_LEAVING  = 2'b01,
        ST_UNBOUND  = 2'b10,
        ST_ARRIVING = 2'b11
    } orbit_state_e;

    // Quarter-wave sine, 8 fraction bits: round(256*sin(k*pi/128)), k = 0..64.
    localparam int SIN_ROM [0:64] = '{
          0,   6,  13,  19,  25,  31,  38,  44,  50,  56,  62,  68,  74,
         80,  86,  92,  98, 104, 109, 115, 121, 126, 132, 137, 142, 147,
        152, 157, 162, 167, 172, 177, 181, 185, 190, 194, 198, 202, 206,
        209, 213, 216, 220, 223, 226, 229, 231, 234, 237, 239, 241, 243,
        245, 247, 248, 250, 251, 252, 253, 254, 255, 255, 256, 256, 256
    };

    orbit_state_e orbit_state;
    logic [7:0]   angle;
    logic         unused_theta_bits;
    int           sin_a;
    int           cos_a;
    int           radius;
    int           sum_x;
    int           sum_y;

    int           pos_x_q, pos_y_q, vel_x_q, vel_y_q;
    logic         edge_hit_q;
    int           pos_x_d, pos_y_d, vel_x_d, vel_y_d;
    logic         edge_hit_d;

    // Full-wave sine by folding the quarter table: the second and fourth
    // quadrants read the table backwards, the lower half-turn negates.
    function automatic int sin_lookup(input logic [7:0] a);
        logic [6:0] idx;
        int         mag;
        idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        mag = SIN_ROM[idx];
        return a[7] ? -mag : mag;
    endfunction

    assign orbit_state       = orbit_state_e'(kin.state);
    assign angle             = kin.theta[7:0];
    assign unused_theta_bits = &{1'b0, kin.theta[31:8]};
    assign sin_a             = sin_lookup(angle);
    assign cos_a             = sin_lookup(angle + 8'd64);
    assign radius            = kin.PlanS + VESSEL_SIZE + ORBIT_GAP;
    assign sum_x             = pos_x_q + vel_x_q;
    assign sum_y             = pos_y_q + vel_y_q;

    // Next-state logic: everything holds by default and each controller
    // state overrides only what it owns. Edge handling looks at the summed
    // position, and X and Y are tested independently so a corner crossing
    // handles both axes in the same frame.
    always_comb begin
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        vel_x_d    = vel_x_q;
        vel_y_d    = vel_y_q;
        edge_hit_d = 1'b0;
        case (orbit_state)
            ST_BOUND: begin
                pos_x_d = kin.PlanX + ((radius * cos_a) >>> 8);
                pos_y_d = kin.PlanY - ((radius * sin_a) >>> 8);
                vel_x_d = 0;
                vel_y_d = 0;
            end
            ST_LEAVING: begin
                vel_x_d = (-(SPEED * sin_a)) >>> 8;
                vel_y_d = (-(SPEED * cos_a)) >>> 8;
            end
            ST_UNBOUND: begin
                pos_x_d = sum_x;
                pos_y_d = sum_y;
`ifdef SCREEN_WRAP_EN
                if (sum_x < 0) begin
                    pos_x_d    = sum_x + SCREEN_W;
                    edge_hit_d = 1'b1;
                end else if (sum_x >= SCREEN_W) begin
                    pos_x_d    = sum_x - SCREEN_W;
                    edge_hit_d = 1'b1;
                end
                if (sum_y < 0) begin
                    pos_y_d    = sum_y + SCREEN_H;
                    edge_hit_d = 1'b1;
                end else if (sum_y >= SCREEN_H) begin
                    pos_y_d    = sum_y - SCREEN_H;
                    edge_hit_d = 1'b1;
                end
`else
                if (sum_x < 0) begin
                    pos_x_d    = 0;
                    vel_x_d    = 0;
                    edge_hit_d = 1'b1;
                end else if (sum_x >= SCREEN_W) begin
                    pos_x_d    = SCREEN_W - 1;
                    vel_x_d    = 0;
                    edge_hit_d = 1'b1;
                end
                if (sum_y < 0) begin
                    pos_y_d    = 0;
                    vel_y_d    = 0;
                    edge_hit_d = 1'b1;
                end else if (sum_y >= SCREEN_H) begin
                    pos_y_d    = SCREEN_H - 1;
                    vel_y_d    = 0;
                    edge_hit_d = 1'b1;
                end
`endif
            end
            ST_ARRIVING: begin
                vel_x_d = 0;
                vel_y_d = 0;
            end
            default: begin
                vel_x_d = 0;
                vel_y_d = 0;
            end
        endcase
    end

    // Output registers; reset wins over whatever state the controller reports.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            pos_x_q    <= START_X;
            pos_y_q    <= START_Y;
            vel_x_q    <= 0;
            vel_y_q    <= 0;
            edge_hit_q <= 1'b0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vel_x_q    <= vel_x_d;
            vel_y_q    <= vel_y_d;
            edge_hit_q <= edge_hit_d;
        end
    end

    assign kin.VesselX  = pos_x_q;
    assign kin.VesselY  = pos_y_q;
    assign kin.VesselS  = VESSEL_SIZE;
    assign kin.vel_x    = vel_x_q;
    assign kin.vel_y    = vel_y_q;
    assign kin.edge_hit = edge_hit_q;

endmodule

// File: tb/tb_vessel_kinematics.sv
// -----------------------------------------------------------------------------
// tb_vessel_kinematics
//
// Purpose: directed, self-checking bench for vessel_kinematics with default
//          parameters. Expected values are hand-computed; the edge cases pick
//          wrap or clamp results according to SCREEN_WRAP_EN.
// -----------------------------------------------------------------------------
module tb_vessel_kinematics;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   total     = 0;
    int   bad       = 0;

    vessel_kinematics_if kin ();

    vessel_kinematics dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .kin       (kin)
    );

    // Free-running frame clock.
    always #5 frame_clk = ~frame_clk;

    // Advance one frame and settle just after the rising edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] st, input int th,
                         input int px, input int py, input int ps);
        kin.state = st;
        kin.theta = th;
        kin.PlanX = px;
        kin.PlanY = py;
        kin.PlanS = ps;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(2'b10, 0, 300, 200, 20);
        tick();
        total++; if (kin.VesselX !== 320) begin bad++; $display("[TB] FAIL reset_x got=%0d want=320", kin.VesselX); end
        total++; if (kin.VesselY !== 240) begin bad++; $display("[TB] FAIL reset_y got=%0d want=240", kin.VesselY); end
        total++; if (kin.vel_x !== 0) begin bad++; $display("[TB] FAIL reset_vx got=%0d want=0", kin.vel_x); end
        total++; if (kin.vel_y !== 0) begin bad++; $display("[TB] FAIL reset_vy got=%0d want=0", kin.vel_y); end
        total++; if (kin.edge_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_hit got=%b want=0", kin.edge_hit); end
        total++; if (kin.VesselS !== 4) begin bad++; $display("[TB] FAIL reset_size got=%0d want=4", kin.VesselS); end
        Reset = 1'b0;
    endtask

    task automatic test_bound();
        int th [5]  = '{0, 64, 128, 32, 192};
        int ex [5]  = '{332, 300, 268, 322, 300};
        int ey [5]  = '{200, 168, 200, 178, 232};
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, th[i], 300, 200, 20);
            tick();
            total++; if (kin.VesselX !== ex[i]) begin bad++; $display("[TB] FAIL bound_x th=%0d got=%0d want=%0d", th[i], kin.VesselX, ex[i]); end
            total++; if (kin.VesselY !== ey[i]) begin bad++; $display("[TB] FAIL bound_y th=%0d got=%0d want=%0d", th[i], kin.VesselY, ey[i]); end
            total++; if (kin.vel_x !== 0 || kin.vel_y !== 0) begin bad++; $display("[TB] FAIL bound_vel th=%0d got=%0d,%0d want=0,0", th[i], kin.vel_x, kin.vel_y); end
        end
        total++; if (kin.VesselS !== 4) begin bad++; $display("[TB] FAIL size got=%0d want=4", kin.VesselS); end
    endtask

    task automatic test_leaving_unbound();
        drive(2'b00, 0, 300, 200, 20);
        tick();
        drive(2'b01, 0, 300, 200, 20);
        tick();
        total++; if (kin.vel_x !== 0) begin bad++; $display("[TB] FAIL leave_vx got=%0d want=0", kin.vel_x); end
        total++; if (kin.vel_y !== -4) begin bad++; $display("[TB] FAIL leave_vy got=%0d want=-4", kin.vel_y); end
        total++; if (kin.VesselX !== 332 || kin.VesselY !== 200) begin bad++; $display("[TB] FAIL leave_hold got=%0d,%0d want=332,200", kin.VesselX, kin.VesselY); end
        drive(2'b10, 0, 300, 200, 20);
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (kin.VesselY !== 200 - 4 * k) begin bad++; $display("[TB] FAIL drift_y step=%0d got=%0d want=%0d", k, kin.VesselY, 200 - 4 * k); end
            total++; if (kin.VesselX !== 332) begin bad++; $display("[TB] FAIL drift_x step=%0d got=%0d want=332", k, kin.VesselX); end
            total++; if (kin.edge_hit !== 1'b0) begin bad++; $display("[TB] FAIL drift_hit step=%0d got=%b want=0", k, kin.edge_hit); end
        end
    endtask

    // theta=224: sin=-181, cos=181 -> vel_x=724>>>8=2, vel_y=-724>>>8=-3.
    task automatic test_shift_rounding();
        drive(2'b01, 224, 300, 200, 20);
        tick();
        total++; if (kin.vel_x !== 2 || kin.vel_y !== -3) begin bad++; $display("[TB] FAIL diag_vel got=%0d,%0d want=2,-3", kin.vel_x, kin.vel_y); end
        total++; if (kin.VesselX !== 332 || kin.VesselY !== 188) begin bad++; $display("[TB] FAIL diag_hold got=%0d,%0d want=332,188", kin.VesselX, kin.VesselY); end
        drive(2'b10, 224, 300, 200, 20);
        tick();
        total++; if (kin.VesselX !== 334 || kin.VesselY !== 185) begin bad++; $display("[TB] FAIL diag_step got=%0d,%0d want=334,185", kin.VesselX, kin.VesselY); end
    endtask

    task automatic test_arriving();
        drive(2'b11, 0, 300, 200, 20);
        tick();
        total++; if (kin.VesselX !== 334 || kin.VesselY !== 185) begin bad++; $display("[TB] FAIL arrive_hold got=%0d,%0d want=334,185", kin.VesselX, kin.VesselY); end
        total++; if (kin.vel_x !== 0 || kin.vel_y !== 0) begin bad++; $display("[TB] FAIL arrive_vel got=%0d,%0d want=0,0", kin.vel_x, kin.vel_y); end
    endtask

    task automatic test_edge_y();
        int exp_y1, exp_vy1, exp_y2;
`ifdef SCREEN_WRAP_EN
        exp_y1 = 478; exp_vy1 = -4; exp_y2 = 474;
`else
        exp_y1 = 0;   exp_vy1 = 0;  exp_y2 = 0;
`endif
        drive(2'b00, 64, 300, 34, 20);
        tick();
        total++; if (kin.VesselX !== 300 || kin.VesselY !== 2) begin bad++; $display("[TB] FAIL edgey_setup got=%0d,%0d want=300,2", kin.VesselX, kin.VesselY); end
        drive(2'b01, 0, 300, 34, 20);
        tick();
        drive(2'b10, 0, 300, 34, 20);
        tick();
        total++; if (kin.VesselY !== exp_y1) begin bad++; $display("[TB] FAIL edgey_y got=%0d want=%0d", kin.VesselY, exp_y1); end
        total++; if (kin.vel_y !== exp_vy1) begin bad++; $display("[TB] FAIL edgey_vy got=%0d want=%0d", kin.vel_y, exp_vy1); end
        total++; if (kin.edge_hit !== 1'b1) begin bad++; $display("[TB] FAIL edgey_hit got=%b want=1", kin.edge_hit); end
        total++; if (kin.VesselX !== 300) begin bad++; $display("[TB] FAIL edgey_x got=%0d want=300", kin.VesselX); end
        tick();
        total++; if (kin.edge_hit !== 1'b0) begin bad++; $display("[TB] FAIL edgey_hit_after got=%b want=0", kin.edge_hit); end
        total++; if (kin.VesselY !== exp_y2) begin bad++; $display("[TB] FAIL edgey_y_after got=%0d want=%0d", kin.VesselY, exp_y2); end
    endtask

    task automatic test_edge_x();
        int exp_x, exp_vx;
`ifdef SCREEN_WRAP_EN
        exp_x = 0;   exp_vx = 4;
`else
        exp_x = 639; exp_vx = 0;
`endif
        drive(2'b00, 0, 600, 200, 20);
        tick();
        drive(2'b01, 192, 600, 200, 20);
        tick();
        total++; if (kin.vel_x !== 4 || kin.vel_y !== 0) begin bad++; $display("[TB] FAIL edgex_vel got=%0d,%0d want=4,0", kin.vel_x, kin.vel_y); end
        drive(2'b10, 192, 600, 200, 20);
        tick();
        total++; if (kin.VesselX !== 636 || kin.edge_hit !== 1'b0) begin bad++; $display("[TB] FAIL edgex_pre got=%0d,%b want=636,0", kin.VesselX, kin.edge_hit); end
        tick();
        total++; if (kin.VesselX !== exp_x) begin bad++; $display("[TB] FAIL edgex_x got=%0d want=%0d", kin.VesselX, exp_x); end
        total++; if (kin.vel_x !== exp_vx) begin bad++; $display("[TB] FAIL edgex_vx got=%0d want=%0d", kin.vel_x, exp_vx); end
        total++; if (kin.edge_hit !== 1'b1) begin bad++; $display("[TB] FAIL edgex_hit got=%b want=1", kin.edge_hit); end
        tick();
        total++; if (kin.edge_hit !== 1'b0) begin bad++; $display("[TB] FAIL edgex_hit_after got=%b want=0", kin.edge_hit); end
    endtask

    // Start at (638,1) with velocity (2,-3): both axes cross in one frame.
    task automatic test_corner();
        int exp_x, exp_y, exp_vx, exp_vy;
`ifdef SCREEN_WRAP_EN
        exp_x = 0;   exp_y = 478; exp_vx = 2; exp_vy = -3;
`else
        exp_x = 639; exp_y = 0;   exp_vx = 0; exp_vy = 0;
`endif
        drive(2'b00, 0, 606, 1, 20);
        tick();
        drive(2'b01, 224, 606, 1, 20);
        tick();
        total++; if (kin.VesselX !== 638 || kin.VesselY !== 1) begin bad++; $display("[TB] FAIL corner_setup got=%0d,%0d want=638,1", kin.VesselX, kin.VesselY); end
        drive(2'b10, 224, 606, 1, 20);
        tick();
        total++; if (kin.VesselX !== exp_x || kin.VesselY !== exp_y) begin bad++; $display("[TB] FAIL corner_pos got=%0d,%0d want=%0d,%0d", kin.VesselX, kin.VesselY, exp_x, exp_y); end
        total++; if (kin.vel_x !== exp_vx || kin.vel_y !== exp_vy) begin bad++; $display("[TB] FAIL corner_vel got=%0d,%0d want=%0d,%0d", kin.vel_x, kin.vel_y, exp_vx, exp_vy); end
        total++; if (kin.edge_hit !== 1'b1) begin bad++; $display("[TB] FAIL corner_hit got=%b want=1", kin.edge_hit); end
    endtask

    // Follows the corner crossing, so edge_hit is high going into reset.
    task automatic test_reset_mid_unbound();
        Reset = 1'b1;
        drive(2'b10, 224, 606, 1, 20);
        tick();
        total++; if (kin.VesselX !== 320 || kin.VesselY !== 240) begin bad++; $display("[TB] FAIL rst_mid_pos got=%0d,%0d want=320,240", kin.VesselX, kin.VesselY); end
        total++; if (kin.vel_x !== 0 || kin.vel_y !== 0) begin bad++; $display("[TB] FAIL rst_mid_vel got=%0d,%0d want=0,0", kin.vel_x, kin.vel_y); end
        total++; if (kin.edge_hit !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_hit got=%b want=0", kin.edge_hit); end
        total++; if (kin.VesselS !== 4) begin bad++; $display("[TB] FAIL rst_mid_size got=%0d want=4", kin.VesselS); end
        Reset = 1'b0;
        drive(2'b11, 0, 606, 1, 20);
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (kin.VesselX !== 320 || kin.VesselY !== 240) begin bad++; $display("[TB] FAIL post_rst_arrive got=%0d,%0d want=320,240", kin.VesselX, kin.VesselY); end
        end
    endtask

    initial begin
        drive(2'b00, 0, 0, 0, 0);
        test_reset();
        test_bound();
        test_leaving_unbound();
        test_shift_rounding();
        test_arriving();
        test_edge_y();
        test_edge_x();
        test_corner();
        test_reset_mid_unbound();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
